// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory access sequencer: FSM encoding, the
// default error read value and the address alignment helper.
package mem_if_pkg;

  typedef enum logic [1:0] {
    MEMIF_IDLE = 2'd0,
    MEMIF_BUSY = 2'd1,
    MEMIF_DONE = 2'd2
  } memif_state_e;

  localparam logic [31:0] MEMIF_ERR_DATA = 32'hDEADBEEF;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/mem_if_if.sv
// Memory-side request/acknowledge bus between the sequencer (master) and
// the unified instruction/data memory (slave).
interface mem_if_if #(
  parameter int WIDTH = 32
);

  logic             m_req;
  logic             m_we;
  logic [WIDTH-1:0] m_adr;
  logic [WIDTH-1:0] m_wd;
  logic             m_ack;
  logic [WIDTH-1:0] m_rd;

  modport master (
    output m_req, m_we, m_adr, m_wd,
    input  m_ack, m_rd
  );

  modport slave (
    input  m_req, m_we, m_adr, m_wd,
    output m_ack, m_rd
  );

endinterface

// File: rtl/mem_if_timer.sv
// Wait-cycle counter for one memory access; expired marks the last BUSY
// cycle allowed before the access is abandoned.
module mem_if_timer
  import mem_if_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT);

  logic [TW-1:0] cnt_r;

  assign expired = (cnt_r == TW'(TIMEOUT - 1));

  // Counter register: cleared at access start, saturates at the limit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= {TW{1'b0}};
    end else if (clr) begin
      cnt_r <= {TW{1'b0}};
    end else if (en && !expired) begin
      cnt_r <= cnt_r + TW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/mem_if.sv
// Memory access sequencer: turns controller fetch/lw/sw cycles into req/ack
// transactions, stalls the controller meanwhile and holds the read data.
module mem_if
  import mem_if_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               TIMEOUT  = 16,
  parameter logic [WIDTH-1:0] ERR_DATA = WIDTH'(MEMIF_ERR_DATA)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             we,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd,
  output logic             stall,
  mem_if_if.master         mem,
  output logic             err_tmo,
  output logic             err_align,
  output logic [15:0]      acc_cnt
);

  memif_state_e     state_r;
  memif_state_e     state_s;
  logic             start_s;
  logic             ack_done_s;
  logic             tmo_done_s;
  logic             busy_s;
  logic             expired_s;

  logic             m_req_r;
  logic             m_we_r;
  logic [WIDTH-1:0] m_adr_r;
  logic [WIDTH-1:0] m_wd_r;
  logic [WIDTH-1:0] rd_r;
  logic             err_tmo_r;
  logic             err_align_r;
  logic [15:0]      acc_cnt_r;

  assign busy_s = (state_r == MEMIF_BUSY);
  assign stall  = ((state_r == MEMIF_IDLE) && req) || busy_s;

  mem_if_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (start_s),
    .en      (busy_s),
    .expired (expired_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= MEMIF_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and the one-cycle event strobes; an ack on the expiry cycle wins.
  always_comb begin
    state_s    = state_r;
    start_s    = 1'b0;
    ack_done_s = 1'b0;
    tmo_done_s = 1'b0;
    case (state_r)
      MEMIF_IDLE: begin
        if (req) begin
          state_s = MEMIF_BUSY;
          start_s = 1'b1;
        end else begin
          state_s = MEMIF_IDLE;
        end
      end
      MEMIF_BUSY: begin
        if (mem.m_ack) begin
          state_s    = MEMIF_DONE;
          ack_done_s = 1'b1;
        end else if (expired_s) begin
          state_s    = MEMIF_DONE;
          tmo_done_s = 1'b1;
        end else begin
          state_s = MEMIF_BUSY;
        end
      end
      MEMIF_DONE: state_s = MEMIF_IDLE;
      default:    state_s = MEMIF_IDLE;
    endcase
  end

  // Capture registers, read-data holding register, sticky flags and counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_req_r     <= 1'b0;
      m_we_r      <= 1'b0;
      m_adr_r     <= {WIDTH{1'b0}};
      m_wd_r      <= {WIDTH{1'b0}};
      rd_r        <= {WIDTH{1'b0}};
      err_tmo_r   <= 1'b0;
      err_align_r <= 1'b0;
      acc_cnt_r   <= 16'd0;
    end else if (start_s) begin
      m_req_r <= 1'b1;
      m_we_r  <= we;
      m_adr_r <= {adr[WIDTH-1:2], 2'b00};
      m_wd_r  <= wd;
      if (is_misaligned(adr[1:0])) begin
        err_align_r <= 1'b1;
      end
    end else if (ack_done_s) begin
      m_req_r   <= 1'b0;
      acc_cnt_r <= acc_cnt_r + 16'd1;
      if (!m_we_r) begin
        rd_r <= mem.m_rd;
      end
    end else if (tmo_done_s) begin
      m_req_r   <= 1'b0;
      err_tmo_r <= 1'b1;
      acc_cnt_r <= acc_cnt_r + 16'd1;
      if (!m_we_r) begin
        rd_r <= ERR_DATA;
      end
    end
  end

  assign mem.m_req  = m_req_r;
  assign mem.m_we   = m_we_r;
  assign mem.m_adr  = m_adr_r;
  assign mem.m_wd   = m_wd_r;
  assign rd         = rd_r;
  assign err_tmo    = err_tmo_r;
  assign err_align  = err_align_r;
  assign acc_cnt    = acc_cnt_r;

endmodule
